// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Two-port arbiter/sequencer in front of the single-port Data_Memory.
//   Port 0 (pipeline LSU) has priority; port 1 (debug/DMA loader) is forced
//   through after STARVE_LIMIT consecutive port-0 grants while it waits.
//   Each granted byte-addressed, sized request becomes one memory access:
//   word address + byte mask + lane-aligned write data. Exactly one response
//   pulse (rvalid, with err) is returned per grant.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   mN_req/we/size/addr/wdata   request N (hold stable until mN_gnt)
//   mN_gnt                 combinational accept, IDLE only
//   mN_rvalid/rdata/err    response pulse two cycles after grant
//   cs, wr, mask, addr, data_wr  Data_Memory pins (cs/wr active low)
//   data_rd                asynchronous read data from Data_Memory
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        cs,
    output logic        wr,
    output logic [3:0]  mask,
    output logic [19:0] addr,
    output logic [31:0] data_wr,
    input  logic [31:0] data_rd
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_t;

    // Misaligned half/word or the reserved size code: granted but never reaches memory.
    function automatic logic req_err(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = off[0];
            2'b10:   req_err = (off != 2'b00);
            default: req_err = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   lane_mask = 4'b0001 << off;
            2'b01:   lane_mask = 4'b0011 << off;
            2'b10:   lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    // Replicating the narrow datum into every lane places it on the lane
    // selected by the offset without a shifter; the mask picks the real lane.
    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'b00:   lane_data = {4{wdata[7:0]}};
            2'b01:   lane_data = {2{wdata[15:0]}};
            default: lane_data = wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [1:0]  size,
                                                 input logic [1:0]  off,
                                                 input logic [31:0] rd);
        logic [31:0] sh;
        sh = rd >> {off, 3'b000};
        case (size)
            2'b00:   load_extract = {24'b0, sh[7:0]};
            2'b01:   load_extract = {16'b0, sh[15:0]};
            default: load_extract = sh;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        off_q, off_d;
    logic              err_q, err_d;
    logic [3:0]        mask_q, mask_d;
    logic [19:0]       addr_q, addr_d;
    logic [31:0]       data_wr_q, data_wr_d;
    logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic              err0_q, err0_d, err1_q, err1_d;
    logic [31:0]       rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic              sel_m1;
    logic              req_we;
    logic [1:0]        req_size;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [31:0]       rsp_data;
    logic              unused_addr_hi;

    assign sel_m1    = m1_req & (~m0_req | (starve_cnt_q == CNT_MAX));
    assign req_we    = sel_m1 ? m1_we    : m0_we;
    assign req_size  = sel_m1 ? m1_size  : m0_size;
    assign req_addr  = sel_m1 ? m1_addr  : m0_addr;
    assign req_wdata = sel_m1 ? m1_wdata : m0_wdata;
    assign unused_addr_hi = ^req_addr[31:22];

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        owner_d      = owner_q;
        we_d         = we_q;
        size_d       = size_q;
        off_d        = off_q;
        err_d        = err_q;
        mask_d       = mask_q;
        addr_d       = addr_q;
        data_wr_d    = data_wr_q;
        rvalid0_d    = 1'b0;
        rvalid1_d    = 1'b0;
        err0_d       = 1'b0;
        err1_d       = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        rsp_data     = 32'd0;

        case (state_q)
            S_IDLE: begin
                if (m0_req | m1_req) begin
                    state_d   = S_ACCESS;
                    owner_d   = sel_m1;
                    we_d      = req_we;
                    size_d    = req_size;
                    off_d     = req_addr[1:0];
                    err_d     = req_err(req_size, req_addr[1:0]);
                    mask_d    = lane_mask(req_size, req_addr[1:0]);
                    addr_d    = req_addr[21:2];
                    data_wr_d = lane_data(req_size, req_wdata);
                end
                // Any IDLE cycle without m1 waiting, or an m1 grant, ends its wait.
                if (!m1_req || sel_m1) begin
                    starve_cnt_d = '0;
                end else if (starve_cnt_q != CNT_MAX) begin
                    starve_cnt_d = starve_cnt_q + 1'b1;
                end
            end
            S_ACCESS: begin
                state_d  = S_IDLE;
                rsp_data = (err_q || we_q) ? 32'd0 : load_extract(size_q, off_q, data_rd);
                if (owner_q) begin
                    rvalid1_d = 1'b1;
                    err1_d    = err_q;
                    rdata1_d  = rsp_data;
                end else begin
                    rvalid0_d = 1'b1;
                    err0_d    = err_q;
                    rdata0_d  = rsp_data;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            starve_cnt_q <= '0;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            off_q        <= 2'b00;
            err_q        <= 1'b0;
            mask_q       <= 4'b0000;
            addr_q       <= 20'd0;
            data_wr_q    <= 32'd0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            rdata0_q     <= 32'd0;
            rdata1_q     <= 32'd0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            size_q       <= size_d;
            off_q        <= off_d;
            err_q        <= err_d;
            mask_q       <= mask_d;
            addr_q       <= addr_d;
            data_wr_q    <= data_wr_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    // Memory pins come straight from state so a write in flight when reset
    // rises still completes on that cycle's falling edge.
    logic access_live;
    assign access_live = (state_q == S_ACCESS) && !err_q;

    assign cs      = ~access_live;
    assign wr      = ~(access_live && we_q);
    assign mask    = access_live ? mask_q : 4'b0000;
    assign addr    = addr_q;
    assign data_wr = data_wr_q;

    assign m0_gnt    = (state_q == S_IDLE) && !rst && m0_req && !sel_m1;
    assign m1_gnt    = (state_q == S_IDLE) && !rst && sel_m1;
    assign m0_rvalid = rvalid0_q;
    assign m1_rvalid = rvalid1_q;
    assign m0_err    = err0_q;
    assign m1_err    = err1_q;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [1:0]  m0_size = 2'b00;
    logic [31:0] m0_addr = 32'd0, m0_wdata = 32'd0;
    logic        m0_gnt, m0_rvalid, m0_err;
    logic [31:0] m0_rdata;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [1:0]  m1_size = 2'b00;
    logic [31:0] m1_addr = 32'd0, m1_wdata = 32'd0;
    logic        m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m1_rdata;
    logic        cs, wr;
    logic [3:0]  mask;
    logic [19:0] addr;
    logic [31:0] data_wr, data_rd;

    dmem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata), .m1_err(m1_err),
        .cs(cs), .wr(wr), .mask(mask), .addr(addr), .data_wr(data_wr),
        .data_rd(data_rd)
    );

    always #5 clk = ~clk;

    // Data_Memory stand-in: asynchronous read, masked write on the falling edge.
    logic [31:0] mem [0:1023];
    assign data_rd = mem[addr[9:0]];
    always @(negedge clk) begin
        if (!cs && !wr) begin
            for (int i = 0; i < 4; i++)
                if (mask[i]) mem[addr[9:0]][8*i +: 8] <= data_wr[8*i +: 8];
        end
    end

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t        sb[$];
    logic [31:0] ref_mem [0:1023];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic m_err(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] m_mask(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b00:   case (off) 2'd0: return 4'b0001; 2'd1: return 4'b0010;
                                2'd2: return 4'b0100; default: return 4'b1000; endcase
            2'b01:   return (off == 2'd0) ? 4'b0011 : 4'b1100;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] m_lane(input logic [1:0] sz, input logic [1:0] off,
                                           input logic [31:0] wd);
        case (sz)
            2'b00:   return 32'(wd[7:0])  << (8 * int'(off));
            2'b01:   return 32'(wd[15:0]) << (8 * int'(off));
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [1:0] off,
                                           input logic [31:0] w);
        logic [31:0] s;
        s = w >> (8 * int'(off));
        case (sz)
            2'b00:   return s & 32'h0000_00FF;
            2'b01:   return s & 32'h0000_FFFF;
            default: return s;
        endcase
    endfunction

    function automatic logic [31:0] bytes_of(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    task automatic drive(input int p, input logic v, input logic we, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
        if (p == 0) begin
            m0_req = v; m0_we = we; m0_size = sz; m0_addr = a; m0_wdata = wd;
        end else begin
            m1_req = v; m1_we = we; m1_size = sz; m1_addr = a; m1_wdata = wd;
        end
    endtask

    task automatic check_rsp(input string tag, input int p);
        rsp_t r;
        chk({tag, "_rvalid"}, 32'({m1_rvalid, m0_rvalid}), (p == 0) ? 32'd1 : 32'd2);
        if (sb.size() == 0) begin
            chk({tag, "_sb_underflow"}, 32'd0, 32'd1);
        end else begin
            r = sb.pop_front();
            chk({tag, "_port"}, 32'(p), 32'(r.port));
            chk({tag, "_rdata"}, (p == 0) ? m0_rdata : m1_rdata, r.rdata);
            chk({tag, "_err"}, 32'((p == 0) ? m0_err : m1_err), 32'(r.err));
        end
    endtask

    // One request from idle: grant, memory cycle, response. Entered and left at posedge+1.
    task automatic txn(input string tag, input int p, input logic we, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
        logic [1:0]  off;
        logic        e;
        logic [3:0]  mk;
        logic [31:0] ln;
        logic [31:0] exp_rd;
        int          idx;
        bit          got;
        rsp_t        r;
        off = a[1:0];
        idx = int'(a[11:2]);
        e   = m_err(sz, off);
        mk  = m_mask(sz, off);
        ln  = m_lane(sz, off, wd);
        exp_rd = 32'd0;
        if (!e && !we) exp_rd = m_load(sz, off, ref_mem[idx]);
        if (!e && we)
            for (int i = 0; i < 4; i++)
                if (mk[i]) ref_mem[idx][8*i +: 8] = ln[8*i +: 8];
        drive(p, 1'b1, we, sz, a, wd);
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            #1;
            if ((p == 0) ? m0_gnt : m1_gnt) got = 1;
            else begin @(posedge clk); #1; end
        end
        chk({tag, "_gnt"}, 32'(got), 32'd1);
        if (!got) begin
            drive(p, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
            return;
        end
        r.port = p; r.rdata = exp_rd; r.err = e;
        sb.push_back(r);
        @(posedge clk); #1;
        drive(p, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        chk({tag, "_cs"}, 32'(cs), 32'(e));
        chk({tag, "_wr"}, 32'(wr), 32'(!(!e && we)));
        chk({tag, "_mask"}, 32'(mask), e ? 32'd0 : 32'(mk));
        if (!e) chk({tag, "_addr"}, 32'(addr), 32'(a[21:2]));
        if (!e && we) chk({tag, "_data_wr"}, data_wr & bytes_of(mk), ln & bytes_of(mk));
        @(posedge clk); #1;
        check_rsp(tag, p);
    endtask

    initial begin
        logic [1:0] exp_g;
        logic [1:0] obs_g;
        rsp_t       r;

        // reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cs", 32'(cs), 32'd1);
        chk("rst_wr", 32'(wr), 32'd1);
        chk("rst_mask", 32'(mask), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_data_wr", data_wr, 32'd0);
        chk("rst_gnt", 32'({m1_gnt, m0_gnt}), 32'd0);
        chk("rst_rvalid", 32'({m1_rvalid, m0_rvalid, m1_err, m0_err}), 32'd0);
        chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // word store/load round trip
        txn("st_word", 0, 1'b1, 2'b10, 32'h100, 32'hCAFEBABE);
        txn("ld_word", 0, 1'b0, 2'b10, 32'h100, 32'd0);
        @(posedge clk); #1;
        chk("rdata_hold", m0_rdata, 32'hCAFEBABE);
        chk("rvalid_pulse", 32'(m0_rvalid), 32'd0);

        // byte merge into an existing word
        txn("st_base", 0, 1'b1, 2'b10, 32'h100, 32'h11223344);
        txn("st_byte3", 0, 1'b1, 2'b00, 32'h103, 32'h000000A5);
        txn("ld_merge", 0, 1'b0, 2'b10, 32'h100, 32'd0);
        txn("ld_byte1", 0, 1'b0, 2'b00, 32'h101, 32'd0);
        txn("st_half2", 1, 1'b1, 2'b01, 32'h102, 32'h0000BEEF);
        txn("ld_half2", 0, 1'b0, 2'b01, 32'h102, 32'd0);
        txn("ld_half0", 1, 1'b0, 2'b01, 32'h100, 32'd0);

        // error requests: granted, no memory access, err pulse, rdata 0
        txn("err_half", 0, 1'b0, 2'b01, 32'h101, 32'd0);
        txn("err_size", 0, 1'b1, 2'b11, 32'h100, 32'hFFFFFFFF);
        txn("err_word", 1, 1'b0, 2'b10, 32'h102, 32'd0);
        txn("after_err", 0, 1'b0, 2'b10, 32'h100, 32'd0);

        // contention: both ports request continuously
        txn("st_m0src", 0, 1'b1, 2'b10, 32'h200, 32'h0BADF00D);
        drive(0, 1'b1, 1'b0, 2'b10, 32'h200, 32'd0);
        drive(1, 1'b1, 1'b0, 2'b01, 32'h102, 32'd0);
        for (int i = 0; i < 10; i++) begin
            #1;
            exp_g = (i % 5 == 4) ? 2'b10 : 2'b01;
            obs_g = {m1_gnt, m0_gnt};
            chk($sformatf("starve_gnt%0d", i), 32'(obs_g), 32'(exp_g));
            r.port  = exp_g[1] ? 1 : 0;
            r.rdata = exp_g[1] ? m_load(2'b01, 2'b10, ref_mem[64]) : ref_mem[128];
            r.err   = 1'b0;
            sb.push_back(r);
            @(posedge clk); #1;
            @(posedge clk); #1;
            check_rsp($sformatf("starve_rsp%0d", i), r.port);
        end
        drive(0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        @(posedge clk); #1;

        // reset during the memory cycle of a store
        drive(0, 1'b1, 1'b1, 2'b10, 32'h300, 32'h12345678);
        #1;
        chk("rstmid_gnt", 32'(m0_gnt), 32'd1);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        chk("rstmid_cs", 32'(cs), 32'd0);
        rst = 1'b1;
        ref_mem[192] = 32'h12345678;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstmid_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
        chk("rstmid_pins", 32'({cs, wr, mask}), 32'b11_0000);
        @(posedge clk); #1;
        chk("rstmid_rvalid2", 32'({m1_rvalid, m0_rvalid}), 32'd0);
        txn("rstmid_ld", 0, 1'b0, 2'b10, 32'h300, 32'd0);
        txn("rstmid_m1", 1, 1'b0, 2'b00, 32'h301, 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
